// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit BCD counter with prescaler, up/down, load and seven-segment decode
// Ports: clkin/rst (async, active-high) | en, up, load, load_val (BCD, digit0 in [3:0])
//        bcd (BCD value), seg ({g..a} per digit), wrap (1-cycle), load_err (1-cycle)
module bcd_counter_n #(
   parameter int DIGITS = 2,
   parameter int MAX    = 99,
   parameter int DIV    = 4
) (
   input  logic                  clkin,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  wrap,
   output logic                  load_err
);
   // decimal MAX converted to BCD by repeated subtraction at elaboration
   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] b;
      int r;
      int p;
      b = '0;
      r = v;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         p = 10 ** i;
         while (r >= p) begin
            r = r - p;
            b[4*i+:4] = b[4*i+:4] + 4'd1;
         end
      end
      return b;
   endfunction
   localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PS_TOP = PW'(DIV - 1);
   localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MAX);
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
   logic [PW-1:0]       r_ps;
   logic [4*DIGITS-1:0] r_bcd;
   logic                r_wrap;
   logic                r_err;
   logic [4*DIGITS-1:0] w_inc;
   logic [4*DIGITS-1:0] w_dec;
   logic [DIGITS-1:0]   w_c;
   logic [DIGITS:0]     w_b;
   logic [DIGITS-1:0]   w_nib_ok;
   logic                w_tick;
   logic                w_load_ok;
   logic                w_at_max;
   assign w_c[0] = 1'b1;
   assign w_b[0] = 1'b1;
   // per-digit ripple: a digit moves only when every lower digit rolls over
   for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      logic [3:0] w_q;
      assign w_q = r_bcd[4*d+:4];
      assign w_inc[4*d+:4] = !w_c[d] ? w_q : w_q == 4'd9 ? 4'd0 : w_q + 4'd1;
      assign w_dec[4*d+:4] = !w_b[d] ? w_q : w_q == 4'd0 ? 4'd9 : w_q - 4'd1;
      assign w_b[d+1] = w_b[d] & (w_q == 4'd0);
      assign w_nib_ok[d] = load_val[4*d+:4] <= 4'd9;
      assign seg[7*d+:7] = SEG_LUT[w_q];
      if (d < DIGITS - 1) begin : g_c
         assign w_c[d+1] = w_c[d] & (w_q == 4'd9);
      end
   end
   assign w_tick    = en && r_ps == PS_TOP;
   assign w_at_max  = r_bcd == MAX_BCD;
   // with all nibbles <= 9, binary compare of BCD words matches decimal order
   assign w_load_ok = &w_nib_ok && load_val <= MAX_BCD;
   assign bcd       = r_bcd;
   assign wrap      = r_wrap;
   assign load_err  = r_err;
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_bcd  <= '0;
         r_ps   <= '0;
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
         if (load) begin
            if (w_load_ok) begin
               r_bcd <= load_val;
               r_ps  <= '0;
            end else r_err <= 1'b1;
         end else if (w_tick) begin
            r_ps   <= '0;
            r_bcd  <= up ? (w_at_max ? '0 : w_inc) : (w_b[DIGITS] ? MAX_BCD : w_dec);
            r_wrap <= up ? w_at_max : w_b[DIGITS];
         end else if (en) r_ps <= r_ps + 1'b1;
      end
   end
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: checks three counter configurations against a decimal reference model
module tb_bcd_counter_n;
   localparam int MAXV [3] = '{99, 59, 999};
   localparam int DIVV [3] = '{4, 4, 1};
   localparam int DIG  [3] = '{2, 2, 3};
   localparam logic [6:0] SEGT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   typedef struct packed {
      int   val;
      int   ps;
      logic w;
      logic e;
   } st_t;
   logic        clk;
   logic        rst;
   logic [2:0]  en;
   logic [2:0]  up;
   logic [2:0]  ld;
   logic [11:0] lv [3];
   logic [7:0]  bcd_a, bcd_b;
   logic [11:0] bcd_c;
   logic [13:0] seg_a, seg_b;
   logic [20:0] seg_c;
   logic [2:0]  o_wrap, o_err;
   logic [11:0] o_bcd [3];
   logic [20:0] o_seg [3];
   st_t         m [3];
   int          errors = 0;
   int          checks = 0;
   bcd_counter_n #(.DIGITS(2), .MAX(99), .DIV(4)) u_a (.clkin(clk), .rst(rst), .en(en[0]), .up(up[0]),
      .load(ld[0]), .load_val(lv[0][7:0]), .bcd(bcd_a), .seg(seg_a), .wrap(o_wrap[0]), .load_err(o_err[0]));
   bcd_counter_n #(.DIGITS(2), .MAX(59), .DIV(4)) u_b (.clkin(clk), .rst(rst), .en(en[1]), .up(up[1]),
      .load(ld[1]), .load_val(lv[1][7:0]), .bcd(bcd_b), .seg(seg_b), .wrap(o_wrap[1]), .load_err(o_err[1]));
   bcd_counter_n #(.DIGITS(3), .MAX(999), .DIV(1)) u_c (.clkin(clk), .rst(rst), .en(en[2]), .up(up[2]),
      .load(ld[2]), .load_val(lv[2]), .bcd(bcd_c), .seg(seg_c), .wrap(o_wrap[2]), .load_err(o_err[2]));
   assign o_bcd[0] = {4'h0, bcd_a};
   assign o_bcd[1] = {4'h0, bcd_b};
   assign o_bcd[2] = bcd_c;
   assign o_seg[0] = {7'h0, seg_a};
   assign o_seg[1] = {7'h0, seg_b};
   assign o_seg[2] = seg_c;
   always #5 clk = ~clk;
   function automatic logic [11:0] tob(input int v);
      logic [11:0] r;
      r = '0;
      for (int k = 0; k < 3; k++) r[4*k+:4] = 4'((v / 10 ** k) % 10);
      return r;
   endfunction
   function automatic logic [20:0] es(input int i);
      logic [20:0] r;
      r = '0;
      for (int k = 0; k < DIG[i]; k++) r[7*k+:7] = SEGT[(m[i].val / 10 ** k) % 10];
      return r;
   endfunction
   // reference: value kept as a plain decimal integer, wrap by modulus
   function automatic st_t step(input st_t s, input int i);
      st_t n;
      int  d;
      int  nib;
      bit  ok;
      n = s;
      n.w = 1'b0;
      n.e = 1'b0;
      if (ld[i]) begin
         d = 0;
         ok = 1'b1;
         for (int k = 0; k < DIG[i]; k++) begin
            nib = int'(lv[i][4*k+:4]);
            if (nib > 9) ok = 1'b0;
            d = d + nib * 10 ** k;
         end
         if (ok && d <= MAXV[i]) begin
            n.val = d;
            n.ps = 0;
         end else n.e = 1'b1;
      end else if (en[i]) begin
         if (s.ps == DIVV[i] - 1) begin
            n.ps = 0;
            n.w = up[i] ? s.val == MAXV[i] : s.val == 0;
            n.val = up[i] ? (s.val + 1) % (MAXV[i] + 1) : (s.val == 0 ? MAXV[i] : s.val - 1);
         end else n.ps = s.ps + 1;
      end
      return n;
   endfunction
   always @(posedge clk or posedge rst)
      for (int i = 0; i < 3; i++) m[i] <= rst ? '0 : step(m[i], i);
   task automatic rand_in(input int i);
      en[i] = $urandom_range(0, 3) != 0;
      up[i] = 1'($urandom);
      ld[i] = $urandom_range(0, 9) == 0;
      lv[i] = $urandom_range(0, 1) != 0 ? tob(int'($urandom_range(0, MAXV[i]))) : 12'($urandom);
   endtask
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_bcd[i] !== 12'h0 || o_wrap[i] !== 1'b0 || o_err[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset u%0d: bcd=%h wrap=%b err=%b, want 0 0 0", i, o_bcd[i], o_wrap[i], o_err[i]);
         end
      end
      checks++;
      if (seg_a !== {2{7'h3F}} || seg_c !== {3{7'h3F}}) begin
         errors++;
         $display("FAIL reset_seg: seg_a=%h seg_c=%h, want %h %h", seg_a, seg_c, {2{7'h3F}}, {3{7'h3F}});
      end
      rst = 1'b0;
   endtask
   task automatic test_count_up;
      int nw;
      nw = 0;
      en[0] = 1'b1;
      up[0] = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({o_bcd[i], o_seg[i], o_wrap[i], o_err[i]} !== {tob(m[i].val), es(i), m[i].w, m[i].e}) begin
               errors++;
               $display("FAIL count_up u%0d t=%0t: bcd=%h seg=%h wrap=%b err=%b, want bcd=%h seg=%h wrap=%b err=%b",
                  i, $time, o_bcd[i], o_seg[i], o_wrap[i], o_err[i], tob(m[i].val), es(i), m[i].w, m[i].e);
            end
         end
         if (o_wrap[0]) nw++;
         if (c == 396) begin
            checks++;
            if (bcd_a !== 8'h99) begin
               errors++;
               $display("FAIL count_up_99: bcd=%h want 99", bcd_a);
            end
         end
         if (c == 400) begin
            checks++;
            if (bcd_a !== 8'h00 || o_wrap[0] !== 1'b1 || seg_a !== {2{7'h3F}}) begin
               errors++;
               $display("FAIL count_up_wrap: bcd=%h wrap=%b seg=%h, want 00 1 %h", bcd_a, o_wrap[0], seg_a, {2{7'h3F}});
            end
         end
         rand_in(1);
         rand_in(2);
      end
      checks++;
      if (nw !== 1) begin
         errors++;
         $display("FAIL count_up_wrap_count: %0d want 1", nw);
      end
      en = '0;
      ld = '0;
   endtask
   task automatic test_carry;
      ld[0] = 1'b1;
      lv[0] = 12'h009;
      @(negedge clk);
      checks++;
      if (bcd_a !== 8'h09 || seg_a !== {7'h3F, 7'h6F}) begin
         errors++;
         $display("FAIL carry_load09: bcd=%h seg=%h, want 09 %h", bcd_a, seg_a, {7'h3F, 7'h6F});
      end
      ld[0] = 1'b0;
      en[0] = 1'b1;
      up[0] = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (bcd_a !== 8'h10 || seg_a !== {7'h06, 7'h3F}) begin
         errors++;
         $display("FAIL carry_up: bcd=%h seg=%h, want 10 %h", bcd_a, seg_a, {7'h06, 7'h3F});
      end
      ld[0] = 1'b1;
      lv[0] = 12'h010;
      en[0] = 1'b0;
      @(negedge clk);
      ld[0] = 1'b0;
      en[0] = 1'b1;
      up[0] = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bcd_a !== 8'h09 || seg_a !== {7'h3F, 7'h6F}) begin
         errors++;
         $display("FAIL borrow_down: bcd=%h seg=%h, want 09 %h", bcd_a, seg_a, {7'h3F, 7'h6F});
      end
      en[0] = 1'b0;
   endtask
   task automatic test_wrap;
      ld[1:0] = 2'b11;
      lv[0] = 12'h000;
      lv[1] = 12'h059;
      @(negedge clk);
      ld[1:0] = 2'b00;
      en[1:0] = 2'b11;
      up[1:0] = 2'b10;
      repeat (3) @(negedge clk);
      checks++;
      if (bcd_a !== 8'h00 || bcd_b !== 8'h59 || o_wrap[1:0] !== 2'b00) begin
         errors++;
         $display("FAIL wrap_pre: a=%h b=%h wrap=%b, want 00 59 00", bcd_a, bcd_b, o_wrap[1:0]);
      end
      @(negedge clk);
      checks++;
      if (bcd_a !== 8'h99 || bcd_b !== 8'h00 || o_wrap[1:0] !== 2'b11) begin
         errors++;
         $display("FAIL wrap_tick: a=%h b=%h wrap=%b, want 99 00 11", bcd_a, bcd_b, o_wrap[1:0]);
      end
      en[0] = 1'b0;
      up[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (o_wrap[1:0] !== 2'b00) begin
         errors++;
         $display("FAIL wrap_one_cycle: wrap=%b want 00", o_wrap[1:0]);
      end
      repeat (2) @(negedge clk);
      @(negedge clk);
      checks++;
      if (bcd_b !== 8'h59 || o_wrap[1] !== 1'b1) begin
         errors++;
         $display("FAIL wrap_down59: b=%h wrap=%b, want 59 1", bcd_b, o_wrap[1]);
      end
      en[1] = 1'b0;
   endtask
   task automatic test_load_err;
      ld[1:0] = 2'b11;
      lv[0] = 12'h07A;
      lv[1] = 12'h060;
      @(negedge clk);
      checks++;
      if (bcd_a !== 8'h99 || bcd_b !== 8'h59 || o_err[1:0] !== 2'b11) begin
         errors++;
         $display("FAIL load_err: a=%h b=%h err=%b, want 99 59 11", bcd_a, bcd_b, o_err[1:0]);
      end
      ld[1:0] = 2'b00;
      @(negedge clk);
      checks++;
      if (o_err[1:0] !== 2'b00 || bcd_a !== 8'h99) begin
         errors++;
         $display("FAIL load_err_pulse: err=%b a=%h, want 00 99", o_err[1:0], bcd_a);
      end
      ld[1:0] = 2'b11;
      lv[0] = 12'h042;
      lv[1] = 12'h042;
      @(negedge clk);
      checks++;
      if (bcd_a !== 8'h42 || bcd_b !== 8'h42 || o_err[1:0] !== 2'b00) begin
         errors++;
         $display("FAIL load_42: a=%h b=%h err=%b, want 42 42 00", bcd_a, bcd_b, o_err[1:0]);
      end
      ld[1:0] = 2'b00;
   endtask
   task automatic test_load_tick;
      ld[0] = 1'b1;
      lv[0] = 12'h020;
      en[0] = 1'b1;
      up[0] = 1'b1;
      @(negedge clk);
      ld[0] = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bcd_a !== 8'h20) begin
         errors++;
         $display("FAIL load_tick_pre: a=%h want 20", bcd_a);
      end
      ld[0] = 1'b1;
      lv[0] = 12'h055;
      @(negedge clk);
      checks++;
      if (bcd_a !== 8'h55 || o_wrap[0] !== 1'b0) begin
         errors++;
         $display("FAIL load_tick: a=%h wrap=%b, want 55 0", bcd_a, o_wrap[0]);
      end
      ld[0] = 1'b0;
      up[0] = 1'b0;
      repeat (3) @(negedge clk);
      up[0] = 1'b1;
      checks++;
      if (bcd_a !== 8'h55) begin
         errors++;
         $display("FAIL load_tick_hold: a=%h want 55", bcd_a);
      end
      @(negedge clk);
      checks++;
      if (bcd_a !== 8'h56) begin
         errors++;
         $display("FAIL load_tick_next: a=%h want 56", bcd_a);
      end
      en[0] = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (bcd_a !== 8'h56) begin
         errors++;
         $display("FAIL en_freeze: a=%h want 56", bcd_a);
      end
   endtask
   task automatic test_async_rst;
      ld[0] = 1'b1;
      lv[0] = 12'h000;
      en[0] = 1'b1;
      up[0] = 1'b0;
      @(negedge clk);
      ld[0] = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bcd_a !== 8'h99 || o_wrap[0] !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: a=%h wrap=%b, want 99 1", bcd_a, o_wrap[0]);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bcd_a !== 8'h00 || o_wrap[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: a=%h wrap=%b, want 00 0", bcd_a, o_wrap[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      up[0] = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bcd_a !== 8'h00) begin
         errors++;
         $display("FAIL async_release_hold: a=%h want 00", bcd_a);
      end
      @(negedge clk);
      checks++;
      if (bcd_a !== 8'h01) begin
         errors++;
         $display("FAIL async_first_tick: a=%h want 01", bcd_a);
      end
      en[0] = 1'b0;
   endtask
   task automatic test_div1;
      ld[2] = 1'b1;
      lv[2] = 12'h995;
      en[2] = 1'b1;
      up[2] = 1'b1;
      @(negedge clk);
      ld[2] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checks++;
         if (bcd_c !== tob((995 + k) % 1000) || o_wrap[2] !== (k == 5)) begin
            errors++;
            $display("FAIL div1_step%0d: c=%h wrap=%b, want %h %b", k, bcd_c, o_wrap[2], tob((995 + k) % 1000), k == 5);
         end
      end
      up[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (bcd_c !== 12'h999 || o_wrap[2] !== 1'b1 || seg_c !== {3{7'h6F}}) begin
         errors++;
         $display("FAIL div1_down: c=%h wrap=%b seg=%h, want 999 1 %h", bcd_c, o_wrap[2], seg_c, {3{7'h6F}});
      end
      en[2] = 1'b0;
   endtask
   task automatic test_random;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 3; i++) rand_in(i);
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({o_bcd[i], o_seg[i], o_wrap[i], o_err[i]} !== {tob(m[i].val), es(i), m[i].w, m[i].e}) begin
               errors++;
               $display("FAIL random u%0d t=%0t: bcd=%h seg=%h wrap=%b err=%b, want bcd=%h seg=%h wrap=%b err=%b",
                  i, $time, o_bcd[i], o_seg[i], o_wrap[i], o_err[i], tob(m[i].val), es(i), m[i].w, m[i].e);
            end
         end
      end
   endtask
   initial begin
      clk = 1'b0;
      rst = 1'b1;
      en = '0;
      up = '0;
      ld = '0;
      for (int i = 0; i < 3; i++) lv[i] = '0;
      test_reset;
      test_count_up;
      test_carry;
      test_wrap;
      test_load_err;
      test_load_tick;
      test_async_rst;
      test_div1;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
